// File: rtl/counter_ctrl_pkg.sv
// Shared types and default sizes for the counter controller.
package counter_ctrl_pkg;

    localparam int unsigned WIDTH_DEF      = 8;
    localparam int unsigned PRESCALE_W_DEF = 4;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StArmed = 2'd1,
        StRun   = 2'd2,
        StDone  = 2'd3
    } state_e;

endpackage

// File: rtl/counter_ctrl_count_core.sv
// count_core: WIDTH-bit count register with synchronous clear, enable and wrap-to-zero.
module count_core #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clr,
    input  logic             i_en,
    input  logic             i_wrap,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_q;

    // Clear wins over counting; a wrap loads zero instead of incrementing.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_en) begin
            r_q <= i_wrap ? '0 : r_q + WIDTH'(1);
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: config handshake, IDLE/ARMED/RUN/DONE sequencing, prescaler, tick/done.
// Optional sticky interrupt (irq/irq_clr) is built when COUNTER_CTRL_IRQ_EN is defined.
module counter_ctrl
    import counter_ctrl_pkg::*;
#(
    parameter int unsigned WIDTH      = WIDTH_DEF,
    parameter int unsigned PRESCALE_W = PRESCALE_W_DEF
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_cfg_valid,
    output logic                  o_cfg_ready,
    input  logic [WIDTH-1:0]      i_cfg_limit,
    input  logic [PRESCALE_W-1:0] i_cfg_prescale,
    input  logic                  i_cfg_periodic,
    input  logic                  i_start,
    input  logic                  i_stop,
    output logic [WIDTH-1:0]      o_q,
    output logic                  o_busy,
    output logic                  o_tick,
    output logic                  o_done
`ifdef COUNTER_CTRL_IRQ_EN
    ,
    output logic                  o_irq,
    input  logic                  i_irq_clr
`endif
);

    state_e                r_state;
    logic [PRESCALE_W-1:0] r_presc;
    logic [WIDTH-1:0]      r_sh_limit;
    logic [PRESCALE_W-1:0] r_sh_presc;
    logic                  r_sh_periodic;
    logic                  r_tick;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_cfg_ready;

    logic [WIDTH-1:0]      w_q;
    logic                  w_hs;
    logic                  w_run_go;
    logic                  w_adv;
    logic                  w_hit;
    logic                  w_tick_set;
    logic                  w_restart;
    logic                  w_clr;
    logic                  w_inc;
    logic                  w_wrap;

    // r_cfg_ready tracks IDLE/DONE exactly, so a handshake can only happen there.
    assign w_hs       = i_cfg_valid & r_cfg_ready;
    assign w_run_go   = (r_state == StRun) & ~i_stop;
    assign w_adv      = w_run_go & (r_presc == r_sh_presc);
    assign w_hit      = w_adv & (w_q == r_sh_limit);
    assign w_tick_set = w_hit;
    assign w_restart  = (r_state == StDone) & ~w_hs & i_start & ~i_stop;
    assign w_clr      = w_hs | w_restart;
    // One-shot holds q at the limit; periodic wraps it to zero.
    assign w_inc      = w_adv & ~(w_hit & ~r_sh_periodic);
    assign w_wrap     = w_hit & r_sh_periodic;

    count_core #(
        .WIDTH (WIDTH)
    ) u_count_core (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_clr  (w_clr),
        .i_en   (w_inc),
        .i_wrap (w_wrap),
        .o_q    (w_q)
    );

    // Sequencing FSM with shadow config, prescaler and registered status outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= StIdle;
            r_presc       <= '0;
            r_sh_limit    <= '0;
            r_sh_presc    <= '0;
            r_sh_periodic <= 1'b0;
            r_tick        <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_cfg_ready   <= 1'b1;
        end else begin
            r_tick <= w_tick_set;
            unique case (r_state)
                StIdle: begin
                    if (w_hs) begin
                        r_sh_limit    <= i_cfg_limit;
                        r_sh_presc    <= i_cfg_prescale;
                        r_sh_periodic <= i_cfg_periodic;
                        r_state       <= StArmed;
                        r_cfg_ready   <= 1'b0;
                    end
                end
                StArmed: begin
                    if (i_stop) begin
                        r_state     <= StIdle;
                        r_cfg_ready <= 1'b1;
                    end else if (i_start) begin
                        r_presc <= '0;
                        r_state <= StRun;
                        r_busy  <= 1'b1;
                    end
                end
                StRun: begin
                    if (i_stop) begin
                        r_state     <= StIdle;
                        r_busy      <= 1'b0;
                        r_cfg_ready <= 1'b1;
                    end else begin
                        r_presc <= w_adv ? '0 : r_presc + PRESCALE_W'(1);
                        if (w_hit && !r_sh_periodic) begin
                            r_state     <= StDone;
                            r_busy      <= 1'b0;
                            r_done      <= 1'b1;
                            r_cfg_ready <= 1'b1;
                        end
                    end
                end
                StDone: begin
                    if (w_hs) begin
                        r_sh_limit    <= i_cfg_limit;
                        r_sh_presc    <= i_cfg_prescale;
                        r_sh_periodic <= i_cfg_periodic;
                        r_state       <= StArmed;
                        r_done        <= 1'b0;
                        r_cfg_ready   <= 1'b0;
                    end else if (w_restart) begin
                        r_presc     <= '0;
                        r_state     <= StRun;
                        r_busy      <= 1'b1;
                        r_done      <= 1'b0;
                        r_cfg_ready <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign o_q         = w_q;
    assign o_busy      = r_busy;
    assign o_tick      = r_tick;
    assign o_done      = r_done;
    assign o_cfg_ready = r_cfg_ready;

`ifdef COUNTER_CTRL_IRQ_EN
    logic r_irq;

    // Sticky interrupt; a clear is overridden on the tick edge and while tick is visible.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_irq <= 1'b0;
        end else if (w_tick_set || r_tick) begin
            r_irq <= 1'b1;
        end else if (i_irq_clr) begin
            r_irq <= 1'b0;
        end
    end

    assign o_irq = r_irq;
`endif

endmodule

// File: tb/tb_counter_ctrl.sv
// Table-driven bench for counter_ctrl with an expectation queue as scoreboard.
module tb_counter_ctrl;

    logic       clk;
    logic       rst;
    logic       cfg_valid;
    logic       cfg_ready;
    logic [7:0] cfg_limit;
    logic [3:0] cfg_prescale;
    logic       cfg_periodic;
    logic       start;
    logic       stop;
    logic [7:0] q;
    logic       busy;
    logic       tick;
    logic       done;
    logic       irq;
    logic       irq_clr;

    int n_cmp;
    int n_bad;

    counter_ctrl #(
        .WIDTH      (8),
        .PRESCALE_W (4)
    ) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_cfg_valid    (cfg_valid),
        .o_cfg_ready    (cfg_ready),
        .i_cfg_limit    (cfg_limit),
        .i_cfg_prescale (cfg_prescale),
        .i_cfg_periodic (cfg_periodic),
        .i_start        (start),
        .i_stop         (stop),
        .o_q            (q),
        .o_busy         (busy),
        .o_tick         (tick),
        .o_done         (done)
`ifdef COUNTER_CTRL_IRQ_EN
        ,
        .o_irq          (irq),
        .i_irq_clr      (irq_clr)
`endif
    );

`ifndef COUNTER_CTRL_IRQ_EN
    assign irq = 1'b0;
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic       cv;
        logic [7:0] lim;
        logic [3:0] pre;
        logic       per;
        logic       st;
        logic       sp;
        logic       clr;
        int         rep;
        logic [7:0] q;
        logic       busy;
        logic       tick;
        logic       done;
        logic       rdy;
        logic       irq;
        logic       chk_irq;
    } vec_t;

    typedef struct {
        string      tag;
        logic [7:0] q;
        logic       busy;
        logic       tick;
        logic       done;
        logic       rdy;
        logic       irq;
        logic       chk_irq;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic vec_t mk(string tag, logic cv, logic [7:0] lim, logic [3:0] pre,
                                logic per, logic st, logic sp, logic clr, int rep,
                                logic [7:0] eq, logic eb, logic et, logic ed, logic er,
                                logic ei, logic ci);
        vec_t v;
        v.tag = tag; v.cv = cv; v.lim = lim; v.pre = pre; v.per = per;
        v.st = st; v.sp = sp; v.clr = clr; v.rep = rep;
        v.q = eq; v.busy = eb; v.tick = et; v.done = ed; v.rdy = er;
        v.irq = ei; v.chk_irq = ci;
        return v;
    endfunction

    task automatic check_outputs(input exp_t e);
        n_cmp++;
        if ({q, busy, tick, done, cfg_ready} !== {e.q, e.busy, e.tick, e.done, e.rdy}) begin
            n_bad++;
            $display("FAIL %s: got q=%0d busy=%b tick=%b done=%b rdy=%b, want q=%0d busy=%b tick=%b done=%b rdy=%b",
                     e.tag, q, busy, tick, done, cfg_ready, e.q, e.busy, e.tick, e.done, e.rdy);
        end
`ifdef COUNTER_CTRL_IRQ_EN
        if (e.chk_irq) begin
            n_cmp++;
            if (irq !== e.irq) begin
                n_bad++;
                $display("FAIL %s_irq: got irq=%b, want irq=%b", e.tag, irq, e.irq);
            end
        end
`endif
    endtask

    // Drive one cycle of inputs, queue the expectation, compare just after the edge.
    task automatic apply(input vec_t v);
        exp_t e;
        for (int r = 0; r < v.rep; r++) begin
            cfg_valid    = v.cv;
            cfg_limit    = v.lim;
            cfg_prescale = v.pre;
            cfg_periodic = v.per;
            start        = v.st;
            stop         = v.sp;
            irq_clr      = v.clr;
            e.tag = v.tag; e.q = v.q; e.busy = v.busy; e.tick = v.tick; e.done = v.done;
            e.rdy = v.rdy; e.irq = v.irq; e.chk_irq = v.chk_irq;
            sb.push_back(e);
            @(posedge clk);
            #1;
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL %s: scoreboard empty, want one entry", v.tag);
            end else begin
                check_outputs(sb.pop_front());
            end
        end
    endtask

    exp_t ex;

    initial begin
        n_cmp = 0;
        n_bad = 0;
        cfg_valid = 0; cfg_limit = 0; cfg_prescale = 0; cfg_periodic = 0;
        start = 0; stop = 0; irq_clr = 0;
        rst = 1'b1;
        #3;
        ex.tag = "reset"; ex.q = 0; ex.busy = 0; ex.tick = 0; ex.done = 0; ex.rdy = 1;
        ex.irq = 0; ex.chk_irq = 1;
        check_outputs(ex);
        @(posedge clk);
        #3 rst = 1'b0;
        @(posedge clk);
        #1;

        //              tag              cv lim pre per st sp clr rep  q  b  t  d  r  irq chk
        // Interrupt set / set-wins-over-clear / clear
        vecs.push_back(mk("irq_cfg",        1, 1, 0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 1));
        vecs.push_back(mk("irq_start",      0, 0, 0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("irq_q1",         0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk("irq_first_tick", 0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk("irq_hold",       0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk("irq_clr_evt",    0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 1, 0, 0, 1, 1));
        vecs.push_back(mk("irq_clr_tick",   0, 0, 0, 0, 0, 0, 1, 1,   1, 1, 0, 0, 0, 1, 1));
        vecs.push_back(mk("irq_stop",       0, 0, 0, 0, 0, 1, 0, 1,   1, 0, 0, 0, 1, 1, 1));
        vecs.push_back(mk("irq_clr_alone",  0, 0, 0, 0, 0, 0, 1, 1,   1, 0, 0, 0, 1, 0, 1));
        // One-shot limit 3, prescale 0
        vecs.push_back(mk("os_cfg",         1, 3, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("os_armed",       0, 0, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("os_start",       0, 0, 0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("os_q1",          0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("os_q2",          0, 0, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("os_q3",          0, 0, 0, 0, 0, 0, 0, 1,   3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("os_tick",        0, 0, 0, 0, 0, 0, 0, 1,   3, 0, 1, 1, 1, 0, 0));
        vecs.push_back(mk("os_done",        0, 0, 0, 0, 0, 0, 0, 2,   3, 0, 0, 1, 1, 0, 0));
        // Restart from DONE reusing the old config
        vecs.push_back(mk("done_restart",   0, 0, 0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rs_q1",          0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rs_q2",          0, 0, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rs_q3",          0, 0, 0, 0, 0, 0, 0, 1,   3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rs_tick",        0, 0, 0, 0, 0, 0, 0, 1,   3, 0, 1, 1, 1, 0, 0));
        // Handshake and start together in DONE: ARMED with new periodic limit 2, prescale 2
        vecs.push_back(mk("done_cfg_start", 1, 2, 2, 1, 1, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_start",      0, 0, 0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_q0",         0, 0, 0, 0, 0, 0, 0, 2,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_q1",         0, 0, 0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_q2",         0, 0, 0, 0, 0, 0, 0, 3,   2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_tick1",      0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("per_q0b",        0, 0, 0, 0, 0, 0, 0, 2,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_q1b",        0, 0, 0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_q2b",        0, 0, 0, 0, 0, 0, 0, 3,   2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_tick2",      0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("per_q0c",        0, 0, 0, 0, 0, 0, 0, 2,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_q1c",        0, 0, 0, 0, 0, 0, 0, 3,   1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("per_q2c",        0, 0, 0, 0, 0, 0, 0, 3,   2, 1, 0, 0, 0, 0, 0));
        // stop on the q==limit advance edge: IDLE, q frozen, no tick
        vecs.push_back(mk("stop_at_limit",  0, 0, 0, 0, 0, 1, 0, 1,   2, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("idle_hold",      0, 0, 0, 0, 0, 0, 0, 1,   2, 0, 0, 0, 1, 0, 0));
        // stop beats start in ARMED; start ignored in IDLE
        vecs.push_back(mk("arm_cfg",        1, 5, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("arm_start_stop", 0, 0, 0, 0, 1, 1, 0, 1,   0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk("idle_start",     0, 0, 0, 0, 1, 0, 0, 1,   0, 0, 0, 0, 1, 0, 0));
        // limit 0, periodic: every advance ticks, q stays 0
        vecs.push_back(mk("l0_cfg",         1, 0, 0, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("l0_start",       0, 0, 0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("l0_tick",        0, 0, 0, 0, 0, 0, 0, 3,   0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(mk("l0_stop",        0, 0, 0, 0, 0, 1, 0, 1,   0, 0, 0, 0, 1, 0, 0));
        // Run up to q=5 ahead of the asynchronous reset
        vecs.push_back(mk("rr_cfg",         1, 9, 0, 0, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rr_start",       0, 0, 0, 0, 1, 0, 0, 1,   0, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rr_q1",          0, 0, 0, 0, 0, 0, 0, 1,   1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rr_q2",          0, 0, 0, 0, 0, 0, 0, 1,   2, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rr_q3",          0, 0, 0, 0, 0, 0, 0, 1,   3, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rr_q4",          0, 0, 0, 0, 0, 0, 0, 1,   4, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk("rr_q5",          0, 0, 0, 0, 0, 0, 0, 1,   5, 1, 0, 0, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
        end

        // Asynchronous reset mid-RUN: outputs return without waiting for a clock edge.
        #2 rst = 1'b1;
        #1;
        ex.tag = "async_rst"; ex.q = 0; ex.busy = 0; ex.tick = 0; ex.done = 0; ex.rdy = 1;
        ex.irq = 0; ex.chk_irq = 1;
        check_outputs(ex);
        @(posedge clk);
        #3 rst = 1'b0;
        apply(mk("post_rst_idle", 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1));

        n_cmp++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL sb_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
